// File: rtl/muldiv_unit.sv
// muldiv_unit: execute-stage multiply/divide unit that owns HI and LO.
// The result is computed when the op is accepted and held in pending
// registers; HI/LO only change when the busy countdown expires, so the
// hazard unit sees a fixed latency for every MULT/DIV.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no op in flight; accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO
// ST_BUSY | op in flight; count runs down, HI/LO commit when it hits zero
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t      state, state_nxt;
  logic [3:0]  count;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;

  logic        is_md, is_div, done;
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_bs, div_bu;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  // Only ops 000..011 occupy the unit; MTHI/MTLO complete in the same edge.
  assign is_md  = start && (op[2] == 1'b0);
  assign is_div = op[1];
  assign done   = (state == ST_BUSY) && (count <= 4'd1);
  assign busy   = (state == ST_BUSY);

  // Operand arithmetic. Signed divide goes through magnitudes so that
  // 0x80000000 / -1 is well defined (quotient wraps to 0x80000000).
  // A zero divisor is replaced by 1 only to keep the divider defined;
  // that result is never committed.
  always_comb begin
    prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u = {32'd0, A} * {32'd0, B};
    abs_a  = A[31] ? (32'd0 - A) : A;
    abs_b  = B[31] ? (32'd0 - B) : B;
    div_bs = (abs_b == 32'd0) ? 32'd1 : abs_b;
    div_bu = (B == 32'd0) ? 32'd1 : B;
    q_mag  = abs_a / div_bs;
    r_mag  = abs_a % div_bs;
    q_s    = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
    r_s    = A[31] ? (32'd0 - r_mag) : r_mag;
    q_u    = A / div_bu;
    r_u    = A % div_bu;
  end

  // Select the HI/LO pair to park in the pending registers.
  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    case (op)
      OP_MULT:  begin {res_hi, res_lo} = prod_s; res_wr = 1'b1; end
      OP_MULTU: begin {res_hi, res_lo} = prod_u; res_wr = 1'b1; end
      OP_DIV:   begin res_hi = r_s; res_lo = q_s; res_wr = (B != 32'd0); end
      OP_DIVU:  begin res_hi = r_u; res_lo = q_u; res_wr = (B != 32'd0); end
      default:  ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; starts while busy are dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (is_md) state_nxt = ST_BUSY;
      ST_BUSY: if (done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Countdown, pending capture, and HI/LO updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else if (state == ST_IDLE) begin
      if (is_md) begin
        count   <= is_div ? DIV_CNT : MULT_CNT;
        pend_hi <= res_hi;
        pend_lo <= res_lo;
        pend_wr <= res_wr;
      end else if (start && op == OP_MTHI) begin
        HI <= A;
      end else if (start && op == OP_MTLO) begin
        LO <= A;
      end
    end else if (done) begin
      count   <= 4'd0;
      pend_wr <= 1'b0;
      if (pend_wr) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end else begin
      count <= count - 4'd1;
    end
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline; owns the architectural HI and LO registers.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from E.
- Models fixed multi-cycle latency with a busy countdown that the hazard unit uses to stall MFHI/MFLO and further md ops in D.
- Its HI/LO values are piped through M to become W_HI/W_LO in the writeback stage.

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU (valid range 1..15)
- DIV_CYCLES, 10, busy duration for DIV/DIVU (valid range 1..15)

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  E-stage md instruction valid this cycle
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
- A  input  32  rs operand (forwarded value)
- B  input  32  rt operand (forwarded value)
- busy  output  1  operation in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, busy=0, counter=0, pending results discarded. Deassertion is sampled synchronously by the next edge.
- State machine:
  - IDLE (busy=0): start with op MULT/MULTU/DIV/DIVU at edge T latches op, A and B (or the computed result) into pending registers, loads counter with MULT_CYCLES or DIV_CYCLES, and moves to BUSY.
  - BUSY (busy=1): counter decrements each edge. On the edge where counter reaches 0, HI/LO take the pending values, busy returns to 0 and the state returns to IDLE, all on that same edge.
- Latency: busy is high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). New HI/LO are visible from the same cycle busy falls. HI/LO hold their old values throughout BUSY.
- MTHI/MTLO in IDLE: HI (or LO) takes A at edge T; busy stays 0; zero latency.
- start while BUSY (any op): ignored. The hazard unit must stall D on busy|start, so this never occurs legally. The bench still checks that the in-flight result is not corrupted.
- Invalid op (110/111) with start: no state change.
- MULT: the 64-bit signed product of A and B splits as HI = upper 32 bits, LO = lower 32 bits.
- MULTU: same split, unsigned product.
- DIV (signed):
  - LO = quotient, truncated toward zero; HI = remainder, taking the sign of the dividend (A).
  - A=0x80000000, B=0xFFFFFFFF gives LO=0x80000000, HI=0x00000000.
- DIVU: unsigned quotient to LO, remainder to HI.
- Divide by zero (B=0, DIV or DIVU):
  - Busy for DIV_CYCLES as normal.
  - HI and LO are left unchanged at completion.
  - No exception is raised.
- Reset mid-BUSY: immediately returns to IDLE; HI/LO=0; the pending result is never committed.
- Operands are captured at the start edge. Later changes on A/B, including forwarding updates, have no effect on an in-flight op.
- No combinational path from start/op/A/B to busy, HI or LO. All three outputs are registered.

Test Plan:
- Reset then MULT: after reset release, start with op=000, A=0xFFFFFFFE (-2), B=3. Required: busy=1 for exactly 5 cycles, HI/LO stay 0 during busy, then HI=0xFFFFFFFF, LO=0xFFFFFFFA on the cycle busy falls.
- MULTU then DIV:
  - MULTU with A=0xFFFFFFFF, B=0xFFFFFFFF gives HI=0xFFFFFFFE, LO=0x00000001.
  - DIV with A=-7 (0xFFFFFFF9), B=2 gives busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide edge cases:
  - DIV 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU 100 by 0 with prior HI=0x11, LO=0x22 gives busy for 10 cycles, then HI=0x11, LO=0x22 unchanged.
- MTHI/MTLO:
  - MTHI with A=0xDEADBEEF at edge T gives HI=0xDEADBEEF after T with busy=0.
  - Back-to-back MTLO with A=0x1234 gives LO=0x1234 on the next edge.
- Start-while-busy: MULT 6×7 in flight; at cycle 2 assert start with DIVU 9/0 and change A/B. Required: the extra start is ignored, busy falls after exactly 5 cycles, HI=0, LO=42.
- Reset mid-op: DIV 100/3 started, reset pulled low at cycle 4 asynchronously (between edges). Required: busy=0, HI=LO=0 immediately; after release, no commit of 33/1 ever appears.
